serial_addsub: RTL
==================

Name: serial_addsub

Overview:
Parametrised multi-cycle adder/subtractor built on the team's ripple full-adder cell. It processes a WIDTH-bit operand pair BPC bits per clock, carrying through a registered carry flop between slices. A start/done handshake lets it sit beside the lab datapath wherever a narrow, area-cheap adder is preferred over a full-width combinational one. It adds a subtract mode, a carry-in, signed overflow detection and result holding, none of which the single-bit cell provides.

Parameters:
WIDTH, 8, operand/result width in bits
BPC, 1, bits processed per clock; WIDTH % BPC must be 0 (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled on rising clk edge
sub  input  1  0 = A+B+cin, 1 = A-B (cin ignored)
cin  input  1  carry-in for add mode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while slices are being computed
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  carry out (sub mode: 1 = no borrow)
ovf  output  1  signed overflow (carry into MSB XOR carry out)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); all state updates on rising clk edge only.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state=IDLE; slice counter=0; carry flop=0.
- States: IDLE, RUN, DONE. S = WIDTH/BPC slices.
- IDLE: start=1 -> latch a, b (b inverted when sub=1), sub; carry flop <= sub ? 1 : cin; counter <= 0; go RUN. start=0 -> stay.
- RUN: busy=1. Each cycle adds slice [k*BPC +: BPC] of latched A and B plus carry flop via a BPC-bit ripple of full-adder cells; writes the slice into the sum register; updates the carry flop; counter increments. After slice S-1 go DONE. start is ignored in RUN (no queueing, no abort).
- sum is written slice by slice in RUN, so intermediate bits are visible but not guaranteed until done.
- DONE: lasts exactly one cycle. done=1, busy=0. cout = final carry; ovf = carry into bit WIDTH-1 XOR cout (registered during the last slice). start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go IDLE.
- Latency: start sampled at edge E0 -> busy high from E0 to E_S -> done high in the cycle following edge E_S, i.e. S+1 cycles after the start edge. Throughput: one operation per S+1 cycles.
- sum, cout and ovf stay constant from done until the first RUN cycle of the next operation.
- Operands and mode may change freely after the start edge; only the latched copies are used.
- rst asserted in any state, including mid-RUN, returns to reset values on that edge; the partial result is discarded and no done pulse is produced.
- rst and start high on the same edge: reset wins.
- Arithmetic is modulo 2^WIDTH; cout/ovf carry the extra information. Sub with a=b gives sum=0, cout=1, ovf=0.

Test Plan:
1. WIDTH=8, BPC=1, add: a=0x5A, b=0x3C, cin=0 -> done exactly 9 cycles after the start edge; sum=0x96, cout=0, ovf=1; busy high for 8 cycles.
2. Add wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
3. Sub: a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. Sub: a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1. Sub: a=0x33, b=0x33 -> sum=0x00, cout=1.
4. BPC=4, WIDTH=8: a=0x5A, b=0x3C -> sum=0x96 with done 3 cycles after the start edge. Pulse start again during the done cycle with a=0x01, b=0x01 -> second done 3 cycles later with sum=0x02.
5. Handshake: pulse start with a=0x01 and b=0x01, then pulse start again mid-RUN with a=0xFF -> ignored, sum=0x02. Change a and b during RUN -> result unaffected.
6. Reset: assert rst for one cycle at slice 4 of an 8-slice run -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows. Assert rst and start together -> reset wins and stays IDLE.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Start/done handshake, operands and result of the serial adder/subtractor.
// The master drives the request side and the slave returns status and result.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: BPC bits per clock through a ripple of full-adder
// cells, with a registered carry between slices and a start/done handshake.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input logic            clk,
    input logic            rst,
    serial_addsub_if.slave bus
);
    localparam int               S           = WIDTH / BPC;
    localparam logic [WIDTH-1:0] FIRST_SLICE = WIDTH'({BPC{1'b1}});

    generate
        if (WIDTH % BPC != 0) begin : g_bad_bpc
            $error("serial_addsub: WIDTH must be a multiple of BPC");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept, last, busy, done;
    logic [WIDTH-1:0] a_q, b_q, sum_q, slice_sel;
    logic             carry_q, cout_q, ovf_q;
    logic [BPC-1:0]   rip_s;
    logic             rip_c, rip_cm;

    // BPC-bit ripple; cm is the carry entering the top bit of the slice.
    function automatic void ripple(input  logic [BPC-1:0] x,
                                   input  logic [BPC-1:0] y,
                                   input  logic           ci,
                                   output logic [BPC-1:0] s,
                                   output logic           co,
                                   output logic           cm);
        logic c;
        c  = ci;
        cm = ci;
        s  = '0;
        for (int i = 0; i < BPC; i++) begin
            cm   = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        co = c;
    endfunction

    always_comb ripple(a_q[BPC-1:0], b_q[BPC-1:0], carry_q, rip_s, rip_c, rip_cm);

    assign last = slice_sel[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands shift down so the active slice is always at bit 0; slice_sel
    // marks where that slice lands in the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            slice_sel <= FIRST_SLICE;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            a_q       <= bus.a;
            b_q       <= bus.sub ? ~bus.b : bus.b;
            carry_q   <= bus.sub ? 1'b1 : bus.cin;
            slice_sel <= FIRST_SLICE;
        end else if (state == RUN) begin
            a_q       <= a_q >> BPC;
            b_q       <= b_q >> BPC;
            carry_q   <= rip_c;
            slice_sel <= slice_sel << BPC;
            sum_q     <= (sum_q & ~slice_sel) | ({S{rip_s}} & slice_sel);
            if (last) begin
                cout_q <= rip_c;
                ovf_q  <= rip_cm ^ rip_c;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule
